// File: rtl/game_flow_ctrl.sv
// Game flow controller for the snoopy game: lives, levels, timed hit/level-up
// holds on frame ticks, result screens released by a fresh key press.
module game_flow_ctrl #(
    parameter int unsigned          COL_W      = 3,
    parameter int unsigned          NUM_LIVES  = 3,
    parameter int unsigned          NUM_LEVELS = 4,
    parameter int unsigned          HOLD_TICKS = 60,
    parameter logic [COL_W-1:0]     COL_IDLE   = 3'b110,
    parameter logic [COL_W-1:0]     COL_PLAY   = 3'b111,
    parameter logic [COL_W-1:0]     COL_HIT    = 3'b101,
    parameter logic [COL_W-1:0]     COL_LVL    = 3'b011,
    parameter logic [COL_W-1:0]     COL_LOST   = 3'b100,
    parameter logic [COL_W-1:0]     COL_WON    = 3'b010,
    localparam int unsigned         LW         = $clog2(NUM_LIVES + 1),
    localparam int unsigned         VW         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_frame_tick,
    input  logic             i_user_input,
    input  logic             i_collided,
    input  logic             i_reached_screen_end,
    output logic [2:0]       o_state,
    output logic [COL_W-1:0] o_col,
    output logic [LW-1:0]    o_lives,
    output logic [VW-1:0]    o_level,
    output logic             o_playing,
    output logic             o_round_start
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StHit      = 3'd2,
        StLevelUp  = 3'd3,
        StGameOver = 3'd4,
        StGameWon  = 3'd5
    } state_e;

    state_e           r_state;
    logic [LW-1:0]    r_lives;
    logic [VW-1:0]    r_level;
    logic [7:0]       r_hold_cnt;
    // Set once the key is seen released on a result screen; a press after that exits.
    logic             r_armed;
    logic [COL_W-1:0] r_col;
    logic             r_playing;
    logic             r_round_start;

    state_e           w_state_d;
    logic [LW-1:0]    w_lives_d;
    logic [VW-1:0]    w_level_d;
    logic [7:0]       w_hold_cnt_d;
    logic             w_armed_d;
    logic             w_round_start_d;
    logic [COL_W-1:0] w_col_d;

    always_comb begin
        w_state_d       = r_state;
        w_lives_d       = r_lives;
        w_level_d       = r_level;
        w_hold_cnt_d    = r_hold_cnt;
        w_armed_d       = r_armed;
        w_round_start_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_user_input) begin
                    w_state_d       = StPlay;
                    w_lives_d       = LW'(NUM_LIVES);
                    w_level_d       = '0;
                    w_round_start_d = 1'b1;
                end
            end
            StPlay: begin
                if (i_collided) begin
                    if (r_lives <= LW'(1)) begin
                        w_lives_d = '0;
                        w_state_d = StGameOver;
                        w_armed_d = 1'b0;
                    end else begin
                        w_lives_d    = r_lives - LW'(1);
                        w_state_d    = StHit;
                        w_hold_cnt_d = '0;
                    end
                end else if (i_reached_screen_end) begin
                    if (r_level >= VW'(NUM_LEVELS - 1)) begin
                        w_state_d = StGameWon;
                        w_armed_d = 1'b0;
                    end else begin
                        w_level_d    = r_level + VW'(1);
                        w_state_d    = StLevelUp;
                        w_hold_cnt_d = '0;
                    end
                end
            end
            StHit, StLevelUp: begin
                if (i_frame_tick) begin
                    if (r_hold_cnt == 8'(HOLD_TICKS - 1)) begin
                        w_state_d       = StPlay;
                        w_hold_cnt_d    = '0;
                        w_round_start_d = 1'b1;
                    end else begin
                        w_hold_cnt_d = r_hold_cnt + 8'd1;
                    end
                end
            end
            StGameOver, StGameWon: begin
                if (!i_user_input) begin
                    w_armed_d = 1'b1;
                end else if (r_armed) begin
                    w_state_d = StIdle;
                    w_armed_d = 1'b0;
                end
            end
            default: begin
                w_state_d    = StIdle;
                w_hold_cnt_d = '0;
                w_armed_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_col_d = COL_IDLE;
        case (w_state_d)
            StPlay:     w_col_d = COL_PLAY;
            StHit:      w_col_d = COL_HIT;
            StLevelUp:  w_col_d = COL_LVL;
            StGameOver: w_col_d = COL_LOST;
            StGameWon:  w_col_d = COL_WON;
            default:    w_col_d = COL_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_lives       <= LW'(NUM_LIVES);
            r_level       <= '0;
            r_hold_cnt    <= '0;
            r_armed       <= 1'b0;
            r_col         <= COL_IDLE;
            r_playing     <= 1'b0;
            r_round_start <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_lives       <= w_lives_d;
            r_level       <= w_level_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_armed       <= w_armed_d;
            r_col         <= w_col_d;
            r_playing     <= (w_state_d == StPlay);
            r_round_start <= w_round_start_d;
        end
    end

    assign o_state       = r_state;
    assign o_col         = r_col;
    assign o_lives       = r_lives;
    assign o_level       = r_level;
    assign o_playing     = r_playing;
    assign o_round_start = r_round_start;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game flow controller for the snoopy game. Generalises the single-round begin/continue/lost/won FSM with several additions: multiple lives, multiple levels, timed result-screen holds driven by a frame tick, and a parametrised status colour output. It sits between the collision/scroll logic, which supplies collided and reached_screen_end, and the VGA/LED display path, which consumes the state, colour, lives and level outputs.

Parameters:
COL_W, 3, width of colour output
NUM_LIVES, 3, lives per game (1..15)
NUM_LEVELS, 4, levels per game (1..16)
HOLD_TICKS, 60, frame ticks spent in HIT and LEVEL_UP before resuming (1..255)
COL_IDLE, 3'b110, colour while idle
COL_PLAY, 3'b111, colour while playing
COL_HIT, 3'b101, colour during hit hold
COL_LVL, 3'b011, colour during level-up hold
COL_LOST, 3'b100, colour on game over
COL_WON, 3'b010, colour on game won

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
frame_tick  in  1  one-cycle enable, once per frame
user_input  in  1  level: user is pressing a key
collided  in  1  level: player overlaps obstacle
reached_screen_end  in  1  level: player reached end of screen
state  out  3  current state encoding
col  out  COL_W  status colour
lives  out  LW = $clog2(NUM_LIVES+1)  remaining lives
level  out  VW = max(1,$clog2(NUM_LEVELS))  current level, 0-based
playing  out  1  high in PLAY only
round_start  out  1  one-cycle pulse on every entry to PLAY

Behaviour:
- All outputs are registered. The asynchronous reset (reset==0) forces:
  - state=IDLE; lives=NUM_LIVES; level=0; col=COL_IDLE; playing=0; round_start=0; hold counter=0.
- State encodings: IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, GAME_OVER=4, GAME_WON=5. Codes 6 and 7 go to IDLE on the next clock.
- Each transition takes effect on the clock edge after its input condition is sampled. Outputs for the new state are valid in the same cycle the state updates.
- IDLE:
  - user_input=1 -> PLAY; lives reloads to NUM_LIVES, level loads 0, round_start pulses.
- PLAY:
  - collided=1 -> if lives==1: lives=0 and go to GAME_OVER; otherwise lives-=1 and go to HIT.
  - Else reached_screen_end=1 -> if level==NUM_LEVELS-1: GAME_WON; otherwise level+=1 and go to LEVEL_UP.
  - collided has priority when both inputs are high in the same cycle.
- HIT and LEVEL_UP:
  - The hold counter clears on entry and increments on each frame_tick.
  - When the counter reaches HOLD_TICKS-1 and frame_tick=1 -> PLAY, and round_start pulses.
  - collided, reached_screen_end and user_input are ignored in these states.
- GAME_OVER and GAME_WON:
  - Stay until user_input is seen low and then high (rising edge detected internally). Then go to IDLE.
  - A key held over from gameplay therefore does not skip the result screen.
- Colour mapping: IDLE->COL_IDLE, PLAY->COL_PLAY, HIT->COL_HIT, LEVEL_UP->COL_LVL, GAME_OVER->COL_LOST, GAME_WON->COL_WON.
- lives never underflows below 0. level never exceeds NUM_LEVELS-1.
- With NUM_LEVELS=1, the first reached_screen_end goes directly to GAME_WON.
- With NUM_LIVES=1, the first collision goes directly to GAME_OVER.
- frame_tick outside HIT and LEVEL_UP has no effect.
- If reset is asserted mid-hold, the controller is in IDLE immediately, with no dependence on the clock.
- No latches. The next-state logic is fully assigned in every branch.

Test Plan:
1. Reset, then user_input=1 for 1 cycle -> state 0->1, round_start high for exactly 1 cycle, lives=3, level=0, col=3'b111.
2. In PLAY, pulse collided -> state=2, lives=2, col=3'b101. Then 60 frame_ticks -> state=1 on the tick-60 edge with round_start pulse. Ticks 1-59 leave state=2.
3. Three collisions, each followed by a full hold -> after the third: state=4, lives=0, col=3'b100. Holding user_input high keeps state=4. Releasing and re-pressing -> state=0.
4. Four reached_screen_end events with holds -> level steps 0,1,2,3; the fourth event gives state=5, col=3'b010, level stays 3.
5. collided and reached_screen_end high in the same PLAY cycle -> state=2, lives decrement, level unchanged.
6. Assert reset asynchronously mid-LEVEL_UP (between clock edges) -> state=0, col=3'b110, lives=3, level=0 immediately. After release, the next user_input starts a fresh game.
